// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// General-purpose register file with an integrated busy-bit scoreboard.
// NREAD combinational read ports with same-cycle write bypass, one write
// (writeback) port that clears the busy bit, and one reservation (issue)
// port that sets it. Decode stalls on rbusy (RAW) and on rsv_ready (WAW).
// When ZERO_REG is 1, index 0 reads as zero, is never busy, drops writes
// and silently accepts reservations.

module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          rsv_en,
    input  logic [ADDR_WIDTH-1:0]         rsv_addr,
    output logic                          rsv_ready,
    input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
    output logic [NREAD*DATA_WIDTH-1:0]   rdata,
    output logic [NREAD-1:0]              rbusy,
    output logic [ADDR_WIDTH:0]           busy_cnt
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam bit                    HAS_ZERO = (ZERO_REG != 0);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Architectural state
    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   busy_cnt_q;
    logic [ADDR_WIDTH:0]   busy_cnt_d;

    // Qualified request strobes
    logic wr_zero;
    logic wr_eff;
    logic rsv_zero;
    logic rsv_hit_wr;
    logic rsv_eff;
    logic cnt_inc;
    logic cnt_dec;

    // Per-port read indices split out of the flat raddr bus
    logic [ADDR_WIDTH-1:0] rd_addr [NREAD];

    for (genvar p = 0; p < NREAD; p++) begin : g_raddr
        assign rd_addr[p] = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Qualify write/reserve requests and decide whether a reservation can be taken
    always_comb begin
        wr_zero    = HAS_ZERO && (waddr == ZERO_IDX);
        wr_eff     = wen && !wr_zero;
        rsv_zero   = HAS_ZERO && (rsv_addr == ZERO_IDX);
        // A writeback to the same register in this cycle frees it in time
        // for the new producer, so the reservation need not stall.
        rsv_hit_wr = wen && (waddr == rsv_addr);
        rsv_ready  = !busy_q[rsv_addr] || rsv_hit_wr || rsv_zero;
        // Reserving the zero register is acknowledged but has no effect.
        rsv_eff    = rsv_en && rsv_ready && !rsv_zero;
    end

    // Next busy vector: writeback clears, reservation sets and wins on a tie
    always_comb begin
        busy_d = busy_q;
        if (wr_eff) begin
            busy_d[waddr] = 1'b0;
        end
        if (rsv_eff) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Track the popcount of busy incrementally from the single set/clear per cycle
    always_comb begin
        cnt_inc    = rsv_eff && !busy_q[rsv_addr];
        cnt_dec    = wr_eff && busy_q[waddr] && !(rsv_eff && (rsv_addr == waddr));
        busy_cnt_d = busy_cnt_q;
        if (cnt_inc && !cnt_dec) begin
            busy_cnt_d = busy_cnt_q + CNT_ONE;
        end else if (cnt_dec && !cnt_inc) begin
            busy_cnt_d = busy_cnt_q - CNT_ONE;
        end
    end

    // State registers; reset clears data as well as scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            if (wr_eff) begin
                rf_q[waddr] <= wdata;
            end
        end
    end

    // Read ports: zero register, then writeback bypass, then stored state
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (HAS_ZERO && (rd_addr[p] == ZERO_IDX)) begin
                rdata[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                rbusy[p]                          = 1'b0;
            end else if (wr_eff && (waddr == rd_addr[p])) begin
                rdata[p*DATA_WIDTH +: DATA_WIDTH] = wdata;
                rbusy[p]                          = 1'b0;
            end else begin
                rdata[p*DATA_WIDTH +: DATA_WIDTH] = rf_q[rd_addr[p]];
                rbusy[p]                          = busy_q[rd_addr[p]];
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard. Two instances share one stimulus stream:
// u_dut_z  (ZERO_REG=1, NREAD=3, DATA_WIDTH=64) and
// u_dut_nz (ZERO_REG=0, NREAD=2, DATA_WIDTH=32, low data bits only).
// The driver predicts each cycle's outputs from an array-based reference
// model and queues them; a negedge monitor pops and compares.

module tb_regfile_scoreboard;

    logic         clk = 1'b0;
    logic         rst;
    logic         wen;
    logic [4:0]   waddr;
    logic [63:0]  wdata;
    logic         rsv_en;
    logic [4:0]   rsv_addr;
    logic [14:0]  raddr;

    logic         rr1;
    logic [191:0] rdata1;
    logic [2:0]   rbusy1;
    logic [5:0]   bc1;

    logic         rr0;
    logic [63:0]  rdata0;
    logic [1:0]   rbusy0;
    logic [5:0]   bc0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .ADDR_WIDTH(5), .DATA_WIDTH(64), .NREAD(3), .ZERO_REG(1)
    ) u_dut_z (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rr1),
        .raddr(raddr), .rdata(rdata1), .rbusy(rbusy1), .busy_cnt(bc1)
    );

    regfile_scoreboard #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2), .ZERO_REG(0)
    ) u_dut_nz (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata[31:0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rr0),
        .raddr(raddr[9:0]), .rdata(rdata0), .rbusy(rbusy0), .busy_cnt(bc0)
    );

    typedef struct packed {
        logic [191:0] rd1;
        logic [2:0]   rb1;
        logic         rr1;
        logic [5:0]   bc1;
        logic [63:0]  rd0;
        logic [1:0]   rb0;
        logic         rr0;
        logic [5:0]   bc0;
    } exp_t;

    exp_t expq[$];

    // Reference model: index 1 = zero-register instance, index 0 = plain
    logic [63:0] m_rf   [2][32];
    bit          m_busy [2][32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic bit is_zero(input int k, input logic [4:0] a);
        return (k == 1) && (a == 5'd0);
    endfunction

    function automatic logic [63:0] m_rd(input int k, input logic [4:0] a);
        if (is_zero(k, a)) return 64'd0;
        if (wen && waddr == a) return wdata;
        return m_rf[k][a];
    endfunction

    function automatic logic m_rb(input int k, input logic [4:0] a);
        if (is_zero(k, a)) return 1'b0;
        if (wen && waddr == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic m_rr(input int k);
        return is_zero(k, rsv_addr) || !m_busy[k][rsv_addr] || (wen && waddr == rsv_addr);
    endfunction

    function automatic logic [5:0] m_cnt(input int k);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[k][i]);
        return 6'(c);
    endfunction

    // Predict this cycle's outputs from current model state and inputs
    task automatic issue();
        exp_t        e;
        logic [63:0] v;
        for (int p = 0; p < 3; p++) begin
            e.rd1[p*64 +: 64] = m_rd(1, raddr[p*5 +: 5]);
            e.rb1[p]          = m_rb(1, raddr[p*5 +: 5]);
        end
        for (int p = 0; p < 2; p++) begin
            v                 = m_rd(0, raddr[p*5 +: 5]);
            e.rd0[p*32 +: 32] = v[31:0];
            e.rb0[p]          = m_rb(0, raddr[p*5 +: 5]);
        end
        e.rr1 = m_rr(1);
        e.rr0 = m_rr(0);
        e.bc1 = m_cnt(1);
        e.bc0 = m_cnt(0);
        expq.push_back(e);
    endtask

    // Apply this cycle's effects to the model at the clock edge
    task automatic advance();
        bit rr [2];
        rr[0] = m_rr(0);
        rr[1] = m_rr(1);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_rf[k][i]   = 64'd0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (wen && !is_zero(k, waddr)) begin
                    m_rf[k][waddr]   = (k == 0) ? {32'd0, wdata[31:0]} : wdata;
                    m_busy[k][waddr] = 1'b0;
                end
                if (rsv_en && rr[k] && !is_zero(k, rsv_addr)) begin
                    m_busy[k][rsv_addr] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic cyc_begin();
        issue();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        rsv_en = 1'b0; rsv_addr = '0; raddr = '0;
    endtask

    task automatic set_ra(input int p, input logic [4:0] a);
        raddr[p*5 +: 5] = a;
    endtask

    // Monitor: compare every presented cycle against the queued prediction
    exp_t mon_e;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("z_rdata%0d", p), rdata1[p*64 +: 64], mon_e.rd1[p*64 +: 64]);
                chk($sformatf("z_rbusy%0d", p), 64'(rbusy1[p]), 64'(mon_e.rb1[p]));
            end
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("nz_rdata%0d", p), 64'(rdata0[p*32 +: 32]), 64'(mon_e.rd0[p*32 +: 32]));
                chk($sformatf("nz_rbusy%0d", p), 64'(rbusy0[p]), 64'(mon_e.rb0[p]));
            end
            chk("z_rsv_ready", 64'(rr1), 64'(mon_e.rr1));
            chk("nz_rsv_ready", 64'(rr0), 64'(mon_e.rr0));
            chk("z_busy_cnt", 64'(bc1), 64'(mon_e.bc1));
            chk("nz_busy_cnt", 64'(bc0), 64'(mon_e.bc0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        advance();

        // Write x5 with bypass, then read back from storage
        idle(); wen = 1'b1; waddr = 5'd5; wdata = 64'hDEADBEEF;
        set_ra(0, 5'd5); set_ra(1, 5'd0);
        cyc_begin();
        chk("x5_bypass_data", rdata1[63:0], 64'hDEADBEEF);
        chk("x5_bypass_busy", 64'(rbusy1[0]), 64'd0);
        chk("x0_read_zero", rdata1[127:64], 64'd0);
        advance();
        idle(); set_ra(0, 5'd5);
        cyc_begin();
        chk("x5_rf_data", rdata1[63:0], 64'hDEADBEEF);
        chk("x5_rf_data_nz", 64'(rdata0[31:0]), 64'hDEADBEEF);
        advance();

        // Reserve x7, retry is refused, writeback clears
        idle(); rsv_en = 1'b1; rsv_addr = 5'd7;
        cyc_begin();
        chk("x7_rsv_ready_free", 64'(rr1), 64'd1);
        advance();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd7; set_ra(0, 5'd7);
        cyc_begin();
        chk("x7_busy", 64'(rbusy1[0]), 64'd1);
        chk("x7_busy_cnt", 64'(bc1), 64'd1);
        chk("x7_rsv_not_ready", 64'(rr1), 64'd0);
        advance();
        idle(); set_ra(0, 5'd7);
        cyc_begin();
        chk("x7_retry_ignored_cnt", 64'(bc1), 64'd1);
        advance();
        idle(); wen = 1'b1; waddr = 5'd7; wdata = 64'h12; set_ra(0, 5'd7);
        cyc_begin();
        chk("x7_wb_busy", 64'(rbusy1[0]), 64'd0);
        chk("x7_wb_data", rdata1[63:0], 64'h12);
        advance();
        idle();
        cyc_begin();
        chk("x7_cleared_cnt", 64'(bc1), 64'd0);
        advance();

        // Write and reserve x0 together
        idle(); wen = 1'b1; waddr = 5'd0; wdata = 64'h55; rsv_en = 1'b1; rsv_addr = 5'd0;
        cyc_begin();
        chk("x0_rsv_ready", 64'(rr1), 64'd1);
        advance();
        idle(); set_ra(0, 5'd0);
        cyc_begin();
        chk("x0_z_data", rdata1[63:0], 64'd0);
        chk("x0_z_busy", 64'(rbusy1[0]), 64'd0);
        chk("x0_z_cnt", 64'(bc1), 64'd0);
        chk("x0_nz_data", 64'(rdata0[31:0]), 64'h55);
        chk("x0_nz_busy", 64'(rbusy0[0]), 64'd1);
        chk("x0_nz_cnt", 64'(bc0), 64'd1);
        advance();

        // Busy x3 hit by write and reserve in the same cycle
        idle(); rsv_en = 1'b1; rsv_addr = 5'd3;
        cyc_begin(); advance();
        idle(); wen = 1'b1; waddr = 5'd3; wdata = 64'hA5A5; rsv_en = 1'b1; rsv_addr = 5'd3;
        cyc_begin();
        chk("x3_tie_ready", 64'(rr1), 64'd1);
        chk("x3_tie_cnt_before", 64'(bc1), 64'd1);
        advance();
        idle(); set_ra(0, 5'd3);
        cyc_begin();
        chk("x3_tie_data", rdata1[63:0], 64'hA5A5);
        chk("x3_tie_busy", 64'(rbusy1[0]), 64'd1);
        chk("x3_tie_cnt_after", 64'(bc1), 64'd1);
        advance();

        // Reserve every nonzero register, then reset with traffic pending
        for (int a = 1; a < 32; a++) begin
            idle(); rsv_en = 1'b1; rsv_addr = 5'(a);
            cyc_begin(); advance();
        end
        idle();
        cyc_begin();
        chk("fill_cnt_31", 64'(bc1), 64'd31);
        advance();
        idle(); rst = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd9;
        wen = 1'b1; waddr = 5'd4; wdata = 64'd77;
        cyc_begin(); advance();
        idle(); set_ra(0, 5'd5); set_ra(1, 5'd3); set_ra(2, 5'd31); rsv_addr = 5'd3;
        cyc_begin();
        chk("rst_cnt", 64'(bc1), 64'd0);
        chk("rst_cnt_nz", 64'(bc0), 64'd0);
        chk("rst_rbusy", 64'(rbusy1), 64'd0);
        chk("rst_rdata", rdata1[191:128] | rdata1[127:64] | rdata1[63:0], 64'd0);
        chk("rst_rsv_ready", 64'(rr1), 64'd1);
        advance();

        // Randomized traffic; narrow address window favours collisions
        for (int n = 0; n < 800; n++) begin
            idle();
            rst      = ($urandom_range(0, 99) == 0);
            wen      = $urandom_range(0, 1) == 1;
            rsv_en   = $urandom_range(0, 1) == 1;
            waddr    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rsv_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wdata    = {$urandom, $urandom};
            for (int p = 0; p < 3; p++) begin
                set_ra(p, ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)));
            end
            cyc_begin(); advance();
        end

        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file with an integrated busy-bit scoreboard, for a pipelined ysyx core. It provides NREAD combinational read ports with same-cycle write bypass, one write port, and one reservation port. Issue marks a destination register busy; writeback clears it. Decode uses the per-port busy flags and the reservation-ready flag to stall on RAW and WAW hazards.

## Interface
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy; when 0 register 0 is an ordinary register

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- wen  input  1  writeback valid
- waddr  input  ADDR_WIDTH  writeback register index
- wdata  input  DATA_WIDTH  writeback data
- rsv_en  input  1  issue request to mark rsv_addr busy
- rsv_addr  input  ADDR_WIDTH  destination register to reserve
- rsv_ready  output  1  reservation at rsv_addr would be accepted this cycle
- raddr  input  NREAD*ADDR_WIDTH  read indices; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  output  NREAD*DATA_WIDTH  read data; port i is bits [i*DATA_WIDTH +: DATA_WIDTH]
- rbusy  output  NREAD  port i register has a pending, not-yet-written value
- busy_cnt  output  ADDR_WIDTH+1  number of registers currently busy

## Operation
- State:
  - rf[2**ADDR_WIDTH] data words.
  - busy[2**ADDR_WIDTH] bits.
  - busy_cnt register.
- Reset: all rf entries are 0, all busy bits are 0, and busy_cnt is 0. Reset overrides wen and rsv_en in the same cycle.
- Zero register (ZERO_REG=1):
  - Writes to index 0 are dropped.
  - Reservations of index 0 are accepted (rsv_ready=1) but change no state.
  - A read of index 0 returns 0 with rbusy=0.
- Write (wen=1, waddr valid): rf[waddr] <= wdata and busy[waddr] <= 0. A write to a non-busy register is legal: data updates and busy stays 0.
- rsv_ready is 1 when any of the following holds:
  - busy[rsv_addr]==0;
  - wen && waddr==rsv_addr in the same cycle;
  - rsv_addr is 0 with ZERO_REG=1.
  rsv_ready does not depend on rsv_en.
- Reserve (rsv_en && rsv_ready): busy[rsv_addr] <= 1.
- Reserve while not ready: the request is ignored with no state change. The requester must hold it and retry, which gives the WAW stall.
- Simultaneous write and reserve to the same index: data is written and busy ends at 1, because the reserve wins. This models back-to-back producers of the same register.
- busy_cnt update, each cycle:
  - +1 if a reserve sets a bit that was 0 and is not also cleared.
  - −1 if a write clears a bit that was 1 and is not re-set.
  - Net 0 in all other cases.
  - busy_cnt always equals the popcount of busy and never exceeds 2**ADDR_WIDTH.
- Read port i (combinational):
  - If wen && waddr==raddr[i] (and not zero-reg), rdata=wdata and rbusy=0 (bypass).
  - Otherwise rdata=rf[raddr[i]] and rbusy=busy[raddr[i]].
  - Duplicate addresses across ports return identical results.

## Timing
- Read latency: 0 cycles; rdata, rbusy and rsv_ready are combinational from their inputs and current state.
- Write latency: the value is visible on rdata in the same cycle through bypass, and in rf from the next cycle.
- A reservation taken in cycle N makes rbusy=1 for that index from cycle N+1.
- A write in cycle N shows rbusy=0 in cycle N (bypass) and from N+1 onward, unless it is re-reserved.
- busy_cnt reflects the updates of cycle N from cycle N+1.
- Reset asserted mid-operation clears everything at the next edge. Outputs read rdata=0, rbusy=0, rsv_ready=1 and busy_cnt=0 from then until new writes arrive.
- No X on outputs after the first reset edge.

## Test plan
- Reset, then write x5=0xDEADBEEF:
  - In the write cycle, raddr[0]=5 gives rdata 0xDEADBEEF with rbusy=0 (bypass).
  - The next cycle, rf read gives the same value.
  - raddr[1]=0 gives 0 throughout.
- Reserve x7 in cycle 1:
  - Cycle 2: rbusy=1, busy_cnt=1, rsv_ready(addr 7)=0.
  - A second rsv_en on 7 is ignored and busy_cnt stays 1.
  - Write x7=0x12 in cycle 4: rbusy=0 that cycle and rdata=0x12; busy_cnt=0 at cycle 5.
- Same-cycle wen waddr=3 and rsv_en rsv_addr=3 with x3 busy:
  - rsv_ready=1.
  - Next cycle rf[3]=wdata, busy[3]=1, busy_cnt unchanged.
- Write/reserve to x0 with ZERO_REG=1:
  - rdata 0, rbusy 0, busy_cnt 0.
- With ZERO_REG=0, the same sequence stores the value and sets the busy bit.
- Reserve all 31 nonzero registers over consecutive cycles:
  - busy_cnt reaches 31.
  - Assert rst mid-sequence: the next cycle shows busy_cnt=0, all rbusy=0, all rdata=0.
- Random traffic on NREAD=3 and DATA_WIDTH=64:
  - Compare against a reference model each cycle: rdata, rbusy, rsv_ready, busy_cnt.
  - busy_cnt equals the popcount of busy.
